// File: rtl/dog_pkg.sv
// Shared widths, requester ids and tag type for the frame-memory read path.
package dog_pkg;

    localparam int unsigned DOG_AW = 16;
    localparam int unsigned DOG_DW = 8;

    typedef logic [0:0] tag_t;

    localparam tag_t RQ_ENGINE = 1'b0;
    localparam tag_t RQ_HOST   = 1'b1;

endpackage

// File: rtl/ram_rd_arbiter_if.sv
// Requester, response and memory read-port signals of the frame-memory read arbiter.
interface ram_rd_arbiter_if import dog_pkg::*; #(
    parameter int unsigned AW = DOG_AW,
    parameter int unsigned DW = DOG_DW
) ();

    logic          rq0_valid_i;
    logic [AW-1:0] rq0_addr_i;
    logic          rq0_ready_o;
    logic          rsp0_valid_o;
    logic [DW-1:0] rsp0_data_o;
    logic          rq1_valid_i;
    logic [AW-1:0] rq1_addr_i;
    logic          rq1_ready_o;
    logic          rsp1_valid_o;
    logic [DW-1:0] rsp1_data_o;
    logic          mem_rd_valid_o;
    logic [AW-1:0] mem_rd_addr_o;
    logic          mem_valid_i;
    logic [DW-1:0] mem_data_i;

    modport slave (
        input  rq0_valid_i, rq0_addr_i, rq1_valid_i, rq1_addr_i, mem_valid_i, mem_data_i,
        output rq0_ready_o, rsp0_valid_o, rsp0_data_o,
        output rq1_ready_o, rsp1_valid_o, rsp1_data_o,
        output mem_rd_valid_o, mem_rd_addr_o
    );

    modport master (
        output rq0_valid_i, rq0_addr_i, rq1_valid_i, rq1_addr_i, mem_valid_i, mem_data_i,
        input  rq0_ready_o, rsp0_valid_o, rsp0_data_o,
        input  rq1_ready_o, rsp1_valid_o, rsp1_data_o,
        input  mem_rd_valid_o, mem_rd_addr_o
    );

endinterface

// File: rtl/ram_rd_tag_fifo.sv
// Synchronous FIFO of requester tags, one per read outstanding at the memory.
module ram_rd_tag_fifo import dog_pkg::*; #(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic          i_pop,
    input  tag_t          i_din,
    output tag_t          o_dout,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    localparam int unsigned PW = $clog2(DEPTH);

    tag_t          r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_dout  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_din;
    end

endmodule

// File: rtl/ram_rd_arbiter.sv
// Round-robin, burst-limited sharing of the frame-memory read port between the
// DoG engine (port 0) and host readout (port 1); returns are steered by a tag FIFO.
module ram_rd_arbiter import dog_pkg::*; #(
    parameter int unsigned AW        = DOG_AW,
    parameter int unsigned DW        = DOG_DW,
    parameter int unsigned MAX_OUT   = 4,
    parameter int unsigned BURST_MAX = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    ram_rd_arbiter_if.slave  bus,
    output logic             busy_o,
    output logic             err_o
);

    localparam int unsigned CW = $clog2(MAX_OUT) + 1;
    localparam int unsigned BW = $clog2(BURST_MAX + 1);

    tag_t          r_owner;
    logic [BW-1:0] r_burst;
    logic          r_mem_rd_valid;
    logic [AW-1:0] r_mem_rd_addr;
    logic          r_rsp0_valid;
    logic [DW-1:0] r_rsp0_data;
    logic          r_rsp1_valid;
    logic [DW-1:0] r_rsp1_data;
    logic          r_err;

    tag_t          w_grant;
    tag_t          w_tag;
    logic          w_own_req;
    logic          w_oth_req;
    logic          w_rdy0;
    logic          w_rdy1;
    logic          w_accept;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;

    assign w_own_req = (r_owner == RQ_HOST) ? bus.rq1_valid_i : bus.rq0_valid_i;
    assign w_oth_req = (r_owner == RQ_HOST) ? bus.rq0_valid_i : bus.rq1_valid_i;

    // Owner keeps the port unless the other side waits and the burst is used up.
    always_comb begin
        w_grant = r_owner;
        if (w_oth_req && (!w_own_req || (r_burst >= BW'(BURST_MAX)))) begin
            w_grant = ~r_owner;
        end
    end

    assign w_rdy0   = (w_grant == RQ_ENGINE) && bus.rq0_valid_i && !w_full;
    assign w_rdy1   = (w_grant == RQ_HOST)   && bus.rq1_valid_i && !w_full;
    assign w_accept = w_rdy0 || w_rdy1;
    assign w_pop    = bus.mem_valid_i && !w_empty;

    ram_rd_tag_fifo #(.DEPTH(MAX_OUT)) u_tag_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_accept),
        .i_pop   (w_pop),
        .i_din   (w_grant),
        .o_dout  (w_tag),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner <= RQ_ENGINE;
            r_burst <= '0;
        end else if (w_accept) begin
            if (w_grant == r_owner) begin
                r_burst <= (r_burst == BW'(BURST_MAX)) ? r_burst : r_burst + BW'(1);
            end else begin
                r_owner <= w_grant;
                r_burst <= BW'(1);
            end
        end
    end

    // Issue to memory one cycle after accept; the address holds while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_rd_valid <= 1'b0;
            r_mem_rd_addr  <= '0;
        end else begin
            r_mem_rd_valid <= w_accept;
            if (w_accept) begin
                r_mem_rd_addr <= (w_grant == RQ_HOST) ? bus.rq1_addr_i : bus.rq0_addr_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp0_valid <= 1'b0;
            r_rsp0_data  <= '0;
            r_rsp1_valid <= 1'b0;
            r_rsp1_data  <= '0;
            r_err        <= 1'b0;
        end else begin
            r_rsp0_valid <= w_pop && (w_tag == RQ_ENGINE);
            r_rsp1_valid <= w_pop && (w_tag == RQ_HOST);
            if (w_pop && (w_tag == RQ_ENGINE)) r_rsp0_data <= bus.mem_data_i;
            if (w_pop && (w_tag == RQ_HOST))   r_rsp1_data <= bus.mem_data_i;
            if (bus.mem_valid_i && w_empty)    r_err       <= 1'b1;
        end
    end

    assign bus.rq0_ready_o    = w_rdy0;
    assign bus.rq1_ready_o    = w_rdy1;
    assign bus.mem_rd_valid_o = r_mem_rd_valid;
    assign bus.mem_rd_addr_o  = r_mem_rd_addr;
    assign bus.rsp0_valid_o   = r_rsp0_valid;
    assign bus.rsp0_data_o    = r_rsp0_data;
    assign bus.rsp1_valid_o   = r_rsp1_valid;
    assign bus.rsp1_data_o    = r_rsp1_data;
    assign busy_o             = (w_count != '0);
    assign err_o              = r_err;

endmodule

// File: tb/tb_ram_rd_arbiter.sv
// Scoreboard bench for ram_rd_arbiter: random and directed traffic against an
// in-order memory model with configurable latency and a rule-level arbitration model.
module tb_ram_rd_arbiter;
    import dog_pkg::*;

    localparam int unsigned AW        = 16;
    localparam int unsigned DW        = 8;
    localparam int unsigned MAX_OUT   = 4;
    localparam int unsigned BURST_MAX = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic busy;
    logic err;
    int   cyc   = 0;

    ram_rd_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    ram_rd_arbiter #(.AW(AW), .DW(DW), .MAX_OUT(MAX_OUT), .BURST_MAX(BURST_MAX)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .busy_o (busy),
        .err_o  (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    function automatic logic [7:0] mem_fn(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hB5;
    endfunction

    // ---------------- memory model: in order, latency lat_min..lat_max ----------------
    typedef struct { logic [15:0] addr; int due; } mrd_t;
    mrd_t mem_q[$];
    int   lat_min = 1;
    int   lat_max = 1;
    int   last_due = 0;
    bit   inject_spur = 1'b0;

    initial begin
        bus.mem_valid_i = 1'b0;
        bus.mem_data_i  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
                mrd_t e;
                e = mem_q.pop_front();
                bus.mem_valid_i = 1'b1;
                bus.mem_data_i  = mem_fn(e.addr);
            end else if (inject_spur) begin
                bus.mem_valid_i = 1'b1;
                bus.mem_data_i  = 8'h77;
                inject_spur     = 1'b0;
            end else begin
                bus.mem_valid_i = 1'b0;
                bus.mem_data_i  = 8'($urandom);
            end
            @(negedge clk);
            if (rst_n && bus.mem_rd_valid_o) begin
                int d;
                d = cyc + int'($urandom_range(lat_max, lat_min));
                if (d <= last_due) d = last_due + 1;
                last_due = d;
                mem_q.push_back('{bus.mem_rd_addr_o, d});
            end
        end
    end

    // ---------------- scoreboard and reference model ----------------
    typedef struct { logic [15:0] addr; int cyc; } iss_t;
    iss_t       iss_q[$];
    logic [7:0] exp0[$];
    logic [7:0] exp1[$];
    int         m_last = 0;
    int         m_run  = 0;
    int         m_out  = 0;
    bit         m_err  = 1'b0;

    always @(negedge clk) begin : monitor
        bit v0, v1, sw, e0, e1, pop, spur;
        int g;
        iss_t it;
        if (rst_n) begin
            v0 = bus.rq0_valid_i;
            v1 = bus.rq1_valid_i;
            if (m_last == 0) sw = v1 && (!v0 || m_run >= int'(BURST_MAX));
            else             sw = v0 && (!v1 || m_run >= int'(BURST_MAX));
            g  = sw ? 1 - m_last : m_last;
            e0 = v0 && (g == 0) && (m_out < int'(MAX_OUT));
            e1 = v1 && (g == 1) && (m_out < int'(MAX_OUT));
            chk("rq0_ready", 32'(bus.rq0_ready_o), 32'(e0));
            chk("rq1_ready", 32'(bus.rq1_ready_o), 32'(e1));
            chk("busy", 32'(busy), 32'(m_out > 0));
            chk("err", 32'(err), 32'(m_err));

            if (bus.mem_rd_valid_o) begin
                if (iss_q.size() == 0) chk("mem_rd_unexpected", 32'(1), 32'(0));
                else begin
                    it = iss_q.pop_front();
                    chk("mem_rd_addr", 32'(bus.mem_rd_addr_o), 32'(it.addr));
                    chk("mem_rd_cycle", 32'(cyc), 32'(it.cyc + 1));
                end
            end else if (iss_q.size() > 0) begin
                it = iss_q.pop_front();
                chk("mem_rd_missing", 32'(0), 32'(1));
            end
            if (bus.rsp0_valid_o) begin
                if (exp0.size() == 0) chk("rsp0_unexpected", 32'(1), 32'(0));
                else chk("rsp0_data", 32'(bus.rsp0_data_o), 32'(exp0.pop_front()));
            end
            if (bus.rsp1_valid_o) begin
                if (exp1.size() == 0) chk("rsp1_unexpected", 32'(1), 32'(0));
                else chk("rsp1_data", 32'(bus.rsp1_data_o), 32'(exp1.pop_front()));
            end

            if (bus.rq0_ready_o) begin
                iss_q.push_back('{bus.rq0_addr_i, cyc});
                exp0.push_back(mem_fn(bus.rq0_addr_i));
            end
            if (bus.rq1_ready_o) begin
                iss_q.push_back('{bus.rq1_addr_i, cyc});
                exp1.push_back(mem_fn(bus.rq1_addr_i));
            end

            pop  = bus.mem_valid_i && (m_out > 0);
            spur = bus.mem_valid_i && (m_out == 0);
            if (e0 || e1) begin
                if ((e1 ? 1 : 0) == m_last) m_run++;
                else begin
                    m_last = e1 ? 1 : 0;
                    m_run  = 1;
                end
            end
            m_out = m_out + ((e0 || e1) ? 1 : 0) - (pop ? 1 : 0);
            m_err = m_err | spur;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit v0, input logic [15:0] a0, input bit v1, input logic [15:0] a1);
        @(posedge clk);
        #1;
        bus.rq0_valid_i = v0;
        bus.rq0_addr_i  = a0;
        bus.rq1_valid_i = v1;
        bus.rq1_addr_i  = a1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (!(m_out == 0 && mem_q.size() == 0 && iss_q.size() == 0 &&
                 exp0.size() == 0 && exp1.size() == 0) && n < 300) begin
            @(posedge clk);
            n++;
        end
        chk("drain", 32'(n < 300), 32'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, n_acc, n_before, pop_cyc, fifth_cyc;
        bus.rq0_valid_i = 1'b0;
        bus.rq0_addr_i  = '0;
        bus.rq1_valid_i = 1'b0;
        bus.rq1_addr_i  = '0;

        // reset state
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_rq0_ready", 32'(bus.rq0_ready_o), 32'(0));
        chk("rst_rq1_ready", 32'(bus.rq1_ready_o), 32'(0));
        chk("rst_mem_rd_valid", 32'(bus.mem_rd_valid_o), 32'(0));
        chk("rst_mem_rd_addr", 32'(bus.mem_rd_addr_o), 32'(0));
        chk("rst_rsp_valid", 32'({bus.rsp0_valid_o, bus.rsp1_valid_o}), 32'(0));
        chk("rst_rsp_data", 32'({bus.rsp0_data_o, bus.rsp1_data_o}), 32'(0));
        chk("rst_busy_err", 32'({busy, err}), 32'(0));
        @(negedge clk);
        #2 rst_n = 1'b1;

        // contention straight out of reset: bursts of BURST_MAX alternate
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 16'(16'h1000 + i), 1'b1, 16'(16'h2000 + i));
            @(negedge clk);
            chk("contention_port", 32'({bus.rq1_ready_o, bus.rq0_ready_o}),
                ((i / 4) % 2 == 0) ? 32'(1) : 32'(2));
        end
        drive(1'b0, '0, 1'b0, '0);
        drain();

        // single read at latency 1: issue at t+1, response at t+3
        drive(1'b1, 16'h0010, 1'b0, '0);
        @(negedge clk);
        chk("single_accept", 32'(bus.rq0_ready_o), 32'(1));
        t = cyc;
        drive(1'b0, '0, 1'b0, '0);
        @(negedge clk);
        chk("single_issue", 32'({bus.mem_rd_valid_o, bus.mem_rd_addr_o}), 32'({1'b1, 16'h0010}));
        @(negedge clk);
        chk("single_rsp_early", 32'(bus.rsp0_valid_o), 32'(0));
        @(negedge clk);
        chk("single_rsp_cycle", 32'(cyc), 32'(t + 3));
        chk("single_rsp0", 32'({bus.rsp0_valid_o, bus.rsp0_data_o}), 32'({1'b1, 8'hA5}));
        chk("single_rsp1", 32'(bus.rsp1_valid_o), 32'(0));
        drain();

        // outstanding limit at latency 8
        lat_min = 8; lat_max = 8;
        n_acc = 0; n_before = 0; pop_cyc = -1; fifth_cyc = -1;
        for (int i = 0; i < 40 && n_acc < 5; i++) begin
            drive(1'b0, '0, 1'b1, 16'(16'h3000 + i));
            @(negedge clk);
            if (bus.mem_valid_i && pop_cyc < 0) pop_cyc = cyc;
            if (bus.rq1_ready_o) begin
                n_acc++;
                if (pop_cyc < 0 || pop_cyc == cyc) n_before++;
                if (n_acc == 5) fifth_cyc = cyc;
            end
        end
        chk("limit_before_pop", 32'(n_before), 32'(4));
        chk("limit_fifth_after_pop", 32'(fifth_cyc), 32'(pop_cyc + 1));
        drive(1'b0, '0, 1'b0, '0);
        drain();

        // idle handoff: lone requester streams, then grant passes once the other asks
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, '0, 1'b1, 16'($urandom));
            @(negedge clk);
            chk("idle_stream", 32'(bus.rq1_ready_o), 32'(1));
        end
        drive(1'b1, 16'h4001, 1'b1, 16'h4002);
        @(negedge clk);
        chk("handoff", 32'({bus.rq1_ready_o, bus.rq0_ready_o}), 32'(1));
        drive(1'b0, '0, 1'b0, '0);
        drain();

        // spurious return with no outstanding tag
        @(negedge clk);
        inject_spur = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("spur_err", 32'(err), 32'(1));
        chk("spur_no_rsp", 32'({bus.rsp0_valid_o, bus.rsp1_valid_o}), 32'(0));
        repeat (5) @(negedge clk);
        chk("spur_err_sticky", 32'(err), 32'(1));

        // random traffic with random in-order memory latency
        lat_min = 1; lat_max = 6;
        for (int i = 0; i < 1500; i++) begin
            drive(($urandom_range(0, 99) < 60), 16'($urandom),
                  ($urandom_range(0, 99) < 60), 16'($urandom));
        end
        drive(1'b0, '0, 1'b0, '0);
        drain();

        // async reset with three reads outstanding
        lat_min = 8; lat_max = 8;
        n_acc = 0;
        for (int i = 0; i < 20 && n_acc < 3; i++) begin
            drive(1'b0, '0, 1'b1, 16'(16'h5000 + i));
            @(negedge clk);
            if (bus.rq1_ready_o) n_acc++;
        end
        drive(1'b0, '0, 1'b0, '0);
        #2;
        chk("pre_reset_busy", 32'(busy), 32'(1));
        rst_n = 1'b0;
        #1;
        chk("areset_mem_rd", 32'({bus.mem_rd_valid_o, bus.mem_rd_addr_o}), 32'(0));
        chk("areset_rsp", 32'({bus.rsp0_valid_o, bus.rsp1_valid_o,
                                bus.rsp0_data_o, bus.rsp1_data_o}), 32'(0));
        chk("areset_busy_err", 32'({busy, err}), 32'(0));
        mem_q.delete();
        iss_q.delete();
        exp0.delete();
        exp1.delete();
        m_last = 0; m_run = 0; m_out = 0; m_err = 1'b0; last_due = 0;
        lat_min = 1; lat_max = 1;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        drive(1'b1, 16'h4444, 1'b1, 16'h5555);
        @(negedge clk);
        chk("post_reset_port0", 32'({bus.rq1_ready_o, bus.rq0_ready_o}), 32'(1));
        drive(1'b0, '0, 1'b0, '0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_rd_arbiter.md
Name: ram_rd_arbiter

Overview:
Shares the single read port (enable/address in, data/valid out) of the 256x256 8-bit frame memory between two requesters: port 0 is the DoG engine and port 1 is the host readout path.
Arbitration is round-robin with a bounded burst lock.
A tag FIFO records which requester issued each read, so every returned datum is steered to its owner in issue order.
It sits between dog_top / host logic and the mem_wrap read port.

Parameters:
AW, 16, address width (65536-pixel frame)
DW, 8, pixel width
MAX_OUT, 4, maximum reads outstanding at the memory (power of 2, 2..16)
BURST_MAX, 16, consecutive grants one requester may hold while the other waits (1..255)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
rq0_valid_i  in  1  port 0 read request
rq0_addr_i  in  AW  port 0 read address
rq0_ready_o  out  1  port 0 request accepted this cycle
rsp0_valid_o  out  1  port 0 read data valid
rsp0_data_o  out  DW  port 0 read data
rq1_valid_i  in  1  port 1 read request
rq1_addr_i  in  AW  port 1 read address
rq1_ready_o  out  1  port 1 request accepted this cycle
rsp1_valid_o  out  1  port 1 read data valid
rsp1_data_o  out  DW  port 1 read data
mem_rd_valid_o  out  1  memory read enable
mem_rd_addr_o  out  AW  memory read address
mem_valid_i  in  1  memory read data valid (any latency of 1 or more cycles; returns in order)
mem_data_i  in  DW  memory read data
busy_o  out  1  tag FIFO not empty
err_o  out  1  sticky: memory returned data with no outstanding tag

Behaviour:
- Reset (async, rst_n=0) values:
  - all outputs 0
  - grant pointer = port 0
  - burst counter = 0
  - tag FIFO empty
  - err_o = 0
- Arbitration (combinational, per cycle):
  - Owner = last granted port.
  - Owner keeps the grant if it is requesting AND (other port is idle OR burst_cnt < BURST_MAX).
  - Otherwise the grant passes to the other port if that port is requesting.
  - If neither port requests, the grant is unchanged.
- rqN_ready_o = grantN AND rqN_valid_i AND (outstanding < MAX_OUT).
  - Ready depends on valid.
  - A pop in the same cycle does not free a slot for the same-cycle push.
- Issue: an accepted request in cycle t produces:
  - mem_rd_valid_o = 1 and mem_rd_addr_o = the granted address in cycle t+1 (registered outputs);
  - a tag push (requester id) in cycle t.
  - When nothing is accepted, mem_rd_valid_o = 0 and mem_rd_addr_o holds its last value.
- Burst counter:
  - increments (saturating at BURST_MAX) on each accept by the current owner;
  - resets to 1 on an accept that switches owner;
  - holds when nothing is accepted.
- Return: mem_valid_i in cycle r pops the tag and produces, in cycle r+1 (registered):
  - rspN_valid_o = 1 for the tagged port only;
  - rspN_data_o = mem_data_i.
  - Data outputs hold their value when valid is 0.
- Total latency accept→response = memory latency + 2. At memory latency 1, sustained throughput is 1 read/cycle.
- Simultaneous push and pop: outstanding count is unchanged and FIFO order is preserved.
- mem_valid_i with the FIFO empty:
  - the datum is dropped (no rsp valid);
  - err_o is set and stays 1 until reset.
- Reset mid-operation discards outstanding tags. The system must idle the memory before asserting rst_n=0.
- Addresses are passed through unmodified; there is no wrap logic in this block.

Decomposition:
- Package dog_pkg:
  - AW / DW defaults;
  - requester-id constants RQ_ENGINE=0, RQ_HOST=1;
  - tag type (1 bit).
- Sub-module ram_rd_tag_fifo: synchronous FIFO of MAX_OUT 1-bit tags. Interfaces:
  - push / pop / din / dout;
  - full / empty;
  - count of width log2(MAX_OUT)+1.
- Arbitration and steering stay in ram_rd_arbiter.

Test Plan:
- Single request, memory latency 1: rq0 addr 0x0010 accepted in cycle t, memory returns 0xA5 → mem_rd_valid_o=1/addr 0x0010 at t+1; rsp0_valid_o=1, data 0xA5 at t+3; rsp1 stays 0.
- Contention, BURST_MAX=4, both ports valid continuously → accept sequence 0,0,0,0,1,1,1,1,0,…; each response goes to the correct port in issue order.
- Outstanding limit, memory latency 8, MAX_OUT=4, rq1 held valid → exactly 4 accepts, then ready=0 until the first mem_valid_i; 5th accept is in the cycle after the pop.
- Idle handoff: only rq1 requesting for 20 cycles, with BURST_MAX=16 → rq1 accepted every cycle (no forced switch to an idle port). rq0 then asserts → grant passes after burst_cnt reaches 16.
- Spurious return: mem_valid_i=1 with empty FIFO → no rsp valid; err_o=1 and remains set until rst_n=0.
- Async reset mid-burst: rst_n low between clock edges with 3 tags outstanding → all outputs 0 immediately; busy_o=0; after release, first accept goes to port 0.
